// File: rtl/inert_intf_mc.sv
// inert_intf_mc: inertial-sensor command sequencer.
// Runs the sensor power-up register writes over the SPI transaction port.
// On each data-ready interrupt it burst-reads NUM_CH 16-bit readings and
// publishes them atomically with a single vld pulse. It also flags
// interrupts that arrive while a burst is still running.
module inert_intf_mc #(
  parameter int                  NUM_CH  = 2,
  parameter logic [8*NUM_CH-1:0] CH_ADDR = {8'h2C, 8'h22},
  parameter int                  INIT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   INT,
  input  logic                   done,
  input  logic [7:0]             rd_data,
  input  logic                   clr_ovr,
  output logic                   wrt,
  output logic [15:0]            cmd,
  output logic [16*NUM_CH-1:0]   data,
  output logic                   vld,
  output logic                   ready,
  output logic                   busy,
  output logic                   ovr
);

  localparam int NB    = 2 * NUM_CH;        // bytes per burst
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    ST_INIT1,
    ST_INIT2,
    ST_INIT3,
    ST_INIT4,
    ST_INITD,
    ST_WAIT,
    ST_RD
  } state_t;

  state_t              r_state;
  logic [INIT_W-1:0]   r_dly;
  logic [IDX_W-1:0]    r_idx;
  logic [8*NB-1:0]     r_shadow;
  logic                r_int_meta;
  logic                r_int_s;
  logic                r_int_s_d;
  logic                w_int_rise;
  logic [8*NB-1:0]     w_frame;

  // Read command for byte i: even bytes hit the channel's low-byte address,
  // odd bytes the address after it. Address bit 7 is the R/W flag slot, so
  // only the low 7 address bits are used.
  function automatic logic [15:0] byte_cmd(input logic [IDX_W-1:0] i);
    logic [6:0] lo;
    lo = CH_ADDR[8*(int'(i) >> 1) +: 7] + 7'(i[0]);
    return {1'b1, lo, 8'h00};
  endfunction

  // Bring the asynchronous interrupt into the clk domain and keep one
  // delayed copy for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchronizer chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
      r_int_s_d  <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
      r_int_s_d  <= r_int_s;
    end
  end

  assign w_int_rise = r_int_s & ~r_int_s_d;

  // Full frame as it will look once the byte arriving now is stored, so the
  // final done can publish everything in the same edge.
  // NOTE: the default copy comes first so every bit of w_frame is assigned
  // on every pass; without it this block would infer latches.
  always_comb begin
    w_frame = r_shadow;
    w_frame[8*int'(r_idx) +: 8] = rd_data;
  end

  // Sequencer: power-up writes, then interrupt-driven burst reads.
  // NOTE: the shadow bytes are an ordinary register vector, not a RAM, so
  // they take the asynchronous reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_INIT1;
      r_dly    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      wrt      <= 1'b0;
      cmd      <= '0;
      data     <= '0;
      vld      <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (r_state)
        ST_INIT1: begin
          r_dly <= r_dly + INIT_W'(1);
          if (&r_dly) begin
            wrt     <= 1'b1;
            cmd     <= 16'h0D02;
            r_state <= ST_INIT2;
          end
        end
        ST_INIT2: if (done) begin
          wrt     <= 1'b1;
          cmd     <= 16'h1053;
          r_state <= ST_INIT3;
        end
        ST_INIT3: if (done) begin
          wrt     <= 1'b1;
          cmd     <= 16'h1150;
          r_state <= ST_INIT4;
        end
        ST_INIT4: if (done) begin
          wrt     <= 1'b1;
          cmd     <= 16'h1460;
          r_state <= ST_INITD;
        end
        ST_INITD: if (done) begin
          ready   <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (r_int_s) begin
          r_idx   <= '0;
          wrt     <= 1'b1;
          cmd     <= byte_cmd('0);
          busy    <= 1'b1;
          r_state <= ST_RD;
        end
        ST_RD: if (done) begin
          r_shadow[8*int'(r_idx) +: 8] <= rd_data;
          if (r_idx == LAST_IDX) begin
            data    <= w_frame;
            vld     <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_WAIT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            wrt   <= 1'b1;
            cmd   <= byte_cmd(r_idx + IDX_W'(1));
          end
        end
        default: r_state <= ST_INIT1;
      endcase
    end
  end

  // Sticky overrun: a new interrupt edge during a burst; setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if ((r_state == ST_RD) && w_int_rise) begin
      ovr <= 1'b1;
    end else if (clr_ovr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: doc/inert_intf_mc.md
# inert_intf_mc

Parametrised multi-channel inertial-sensor command sequencer. It runs the sensor power-up configuration over the existing SPI transaction port, then on every data-ready interrupt burst-reads `NUM_CH` 16-bit readings. Readings are presented atomically with a single `vld` pulse. It sits between the SPI master and the inertial integrator / balance controller, and flags interrupts that arrive while a burst is still in progress.

## Interface
- `NUM_CH`, 2: number of 16-bit channels read per interrupt (1..4).
- `CH_ADDR`, {8'h2C, 8'h22}: packed `8*NUM_CH` low-byte register addresses; channel k = bits `[8k+7:8k]`; high byte is read from address+1.
- `INIT_W`, 16: width of the power-up delay counter.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `INT` in 1: sensor data-ready, asynchronous to `clk`.
- `done` in 1: SPI master transaction-complete pulse.
- `rd_data` in 8: SPI read byte; valid when `done`=1.
- `clr_ovr` in 1: synchronous clear of `ovr`.
- `wrt` out 1: one-cycle SPI transaction start.
- `cmd` out 16: SPI command word, held stable from `wrt` until `done`.
- `data` out `16*NUM_CH`: channel k in `[16k+15:16k]`, as {high byte, low byte}.
- `vld` out 1: one-cycle pulse; `data` updated this cycle.
- `ready` out 1: configuration complete.
- `busy` out 1: burst read in progress.
- `ovr` out 1: sticky overrun flag.

## Operation
- `INT` is double-flopped to `INT_s`; `INT_s` is registered once more for rising-edge detect.
- States: `INIT1`, `INIT2`, `INIT3`, `INIT4`, `INITD`, `WAIT`, `RD`.
- `INIT1`: the delay counter free-runs from 0. When it is all-ones, pulse `wrt` with `cmd`=16'h0D02 and go to `INIT2`.
- `INIT2`, `INIT3`, `INIT4`: on `done`, pulse `wrt` with 16'h1053, 16'h1150 and 16'h1460 respectively, then advance to `INIT3`, `INIT4`, `INITD`.
- `INITD`: on `done`, go to `WAIT` and set `ready`=1. `ready` stays 1 until reset.
- `WAIT`: if `INT_s`=1, clear the byte index `idx` to 0, pulse `wrt` with the byte-0 command, and go to `RD`.
- Byte command for index i: `{1'b1, a[6:0], 8'h00}`.
  - a = `CH_ADDR` entry for channel i/2.
  - Add 1 when i is odd.
  - Bit 7 of `CH_ADDR` entries is ignored.
- `RD`: on `done`, store `rd_data` into shadow byte `idx`.
  - If `idx` = 2*`NUM_CH`-1: copy the whole shadow into `data`, pulse `vld`, go to `WAIT`.
  - Otherwise: increment `idx` and pulse `wrt` with the next command in the same cycle.
- `data` changes only on `vld` cycles, so there is never a mixed old/new frame.
- `busy`=1 exactly while in `RD`.
- Overrun: a rising edge of `INT_s` while in `RD` sets `ovr`. The burst continues unaffected.
- `clr_ovr` clears `ovr`. If set and clear occur in the same cycle, set wins.
- `cmd` outside active transactions holds its last value; `cmd` is 0 after reset.
- `done` arriving in `INIT1` or `WAIT` is ignored.

## Timing
- Reset values:
  - `wrt`, `vld`, `ready`, `busy`, `ovr` = 0.
  - `cmd`, `data`, shadow, `idx`, delay counter = 0.
  - State = `INIT1`.
- First `wrt` occurs 2^`INIT_W` cycles after reset release.
- `INT` to first `wrt`: 3 cycles (2 sync flops + 1 cycle in `WAIT`).
- `wrt` for the next byte is in the same cycle as the `done` of the previous byte. There are no idle cycles between transactions.
- `vld` is in the same cycle as the final `done`. The next burst can begin on the following cycle if `INT_s`=1.
- If `INT` is still high on return to `WAIT` (sensor not yet deasserted), a new burst starts. This behaviour is intended.
- Reset mid-burst aborts immediately: no `vld`, `data` cleared, full re-initialisation including the power-up delay.

## Test plan
- Init sequence (`INIT_W`=4, `done` 5 cycles after each `wrt`):
  - First `wrt` at cycle 16 after reset, `cmd`=16'h0D02.
  - Then 16'h1053, 16'h1150, 16'h1460.
  - `ready` rises on the 4th `done`.
- Burst, `NUM_CH`=2, default `CH_ADDR`, `INT` pulsed:
  - Commands are 16'hA200, A300, AC00, AD00.
  - Return `rd_data` 0x34, 0x12, 0x78, 0x56.
  - Expect one `vld` with `data`=32'h5678_1234; `busy` is low afterwards.
- Atomicity: during a second burst returning 0xAA bytes, `data` holds 32'h5678_1234 until the final `done`, then becomes 32'hAAAA_AAAA.
- Overrun:
  - `INT` deasserted then reasserted mid-burst -> `ovr`=1 and the burst completes normally.
  - `clr_ovr` asserted coincident with a new overrun edge -> `ovr` stays 1.
  - `clr_ovr` alone -> `ovr`=0.
- `NUM_CH`=4, `CH_ADDR`={8'h2C,8'h26,8'h24,8'h22}: 8 transactions in address order 22,23,24,25,26,27,2C,2D; a single `vld` at the end.
- Reset asserted after the 2nd `done` of a burst: all outputs return to 0, no `vld`, and the next `wrt` is 16'h0D02 after the delay.
